// File: rtl/sys_onchip_mem_pkg.sv
// Shared definitions for the on-chip memory arbiter.
//   DEF_ADDR_W / DEF_DATA_W / DEF_BURST_W : default port widths
//   arb_state_e                           : arbiter FSM state encoding
package sys_onchip_mem_pkg;

  localparam int DEF_ADDR_W  = 13;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_BURST_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_BURST = 2'd1,
    ST_WR_BURST = 2'd2
  } arb_state_e;

endpackage

// File: rtl/sys_rr_grant2.sv
// Two-way round-robin grant selection (purely combinational).
//   req        : request vector, bit N = port N
//   last_grant : index of the port granted most recently
//   grant      : one-hot grant, all-zero when nothing is requested
module sys_rr_grant2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // On a tie the port that did not win last time goes next.
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/sys_onchip_mem_arbiter.sv
// Two-port burst arbiter in front of a single-port on-chip RAM.
//   clk, reset             : clock, asynchronous active-high reset
//   mN_*  (N = 0,1)        : requester ports (address, byteenable, read,
//                            write, writedata, burstcount, waitrequest,
//                            readdata, readdatavalid)
//   mem_*                  : RAM port; mem_readdata is valid one cycle
//                            after the address cycle
//   dbg_state              : current FSM state, for observation only
//
// Handshake: a requester holds its command (read/write, address, data,
// burstcount) stable while waitrequest is high; a command or write beat
// is accepted in a cycle where its strobe is high and waitrequest is low.
// Read data returns on mN_readdatavalid exactly one cycle after each RAM
// read address cycle; there is no backpressure on read data.
module sys_onchip_mem_arbiter
  import sys_onchip_mem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int BURST_W = DEF_BURST_W
) (
  input  logic                clk,
  input  logic                reset,

  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [BURST_W-1:0]  m0_burstcount,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,

  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [BURST_W-1:0]  m1_burstcount,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,

  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  input  logic [DATA_W-1:0]   mem_readdata,

  output arb_state_e          dbg_state
);

  localparam int BE_W = DATA_W / 8;

  arb_state_e          state_q, state_d;
  logic                owner_q, owner_d;      // port that owns the burst
  logic                last_q, last_d;        // port granted most recently
  logic [BURST_W-1:0]  cnt_q, cnt_d;          // beats still to issue
  logic [ADDR_W-1:0]   addr_q, addr_d;        // next burst address
  logic [1:0]          rdv_q;                 // registered read-issue strobes
  logic [1:0]          rd_issue;

  logic [1:0]          req;
  logic [1:0]          grant;
  logic                sel;

  logic [ADDR_W-1:0]   sel_addr;
  logic [BE_W-1:0]     sel_be;
  logic                sel_wr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [BURST_W-1:0]  sel_burst;

  logic                own_write;
  logic [BE_W-1:0]     own_be;
  logic [DATA_W-1:0]   own_wdata;

  assign req = {m1_read | m1_write, m0_read | m0_write};

  sys_rr_grant2 u_rr_grant (
    .req        (req),
    .last_grant (last_q),
    .grant      (grant)
  );

  assign sel = grant[1];

  // Command fields of the port being granted in IDLE. A port asserting
  // both read and write is treated as a writer.
  assign sel_addr  = sel ? m1_address    : m0_address;
  assign sel_be    = sel ? m1_byteenable : m0_byteenable;
  assign sel_wr    = sel ? m1_write      : m0_write;
  assign sel_wdata = sel ? m1_writedata  : m0_writedata;
  assign sel_burst = sel ? m1_burstcount : m0_burstcount;

  // Write-beat fields of the current burst owner.
  assign own_write = owner_q ? m1_write      : m0_write;
  assign own_be    = owner_q ? m1_byteenable : m0_byteenable;
  assign own_wdata = owner_q ? m1_writedata  : m0_writedata;

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_d         = last_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_address    = addr_q;
    mem_byteenable = '1;
    mem_writedata  = own_wdata;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    rd_issue       = 2'b00;

    // Reset gates every strobe so nothing is accepted or issued while it
    // is asserted, independent of the clock.
    if (!reset) begin
      case (state_q)
        ST_IDLE: begin
          if (|grant) begin
            mem_chipselect = 1'b1;
            mem_address    = sel_addr;
            mem_write      = sel_wr;
            mem_byteenable = sel_wr ? sel_be : '1;
            mem_writedata  = sel_wdata;
            if (sel) m1_waitrequest = 1'b0;
            else     m0_waitrequest = 1'b0;
            if (!sel_wr) rd_issue[sel] = 1'b1;
            last_d = sel;
            // Burstcount 0 or 1 is a single access and stays in IDLE.
            if (sel_burst > BURST_W'(1)) begin
              owner_d = sel;
              cnt_d   = sel_burst - BURST_W'(1);
              addr_d  = sel_addr + ADDR_W'(1);
              state_d = sel_wr ? ST_WR_BURST : ST_RD_BURST;
            end
          end
        end

        ST_RD_BURST: begin
          // One address per cycle; both ports stay stalled.
          mem_chipselect    = 1'b1;
          rd_issue[owner_q] = 1'b1;
          cnt_d             = cnt_q - BURST_W'(1);
          addr_d            = addr_q + ADDR_W'(1);
          if (cnt_q == BURST_W'(1)) state_d = ST_IDLE;
        end

        ST_WR_BURST: begin
          // A cycle without the owner's write strobe is a stall bubble.
          if (own_write) begin
            mem_chipselect = 1'b1;
            mem_write      = 1'b1;
            mem_byteenable = own_be;
            if (owner_q) m1_waitrequest = 1'b0;
            else         m0_waitrequest = 1'b0;
            cnt_d  = cnt_q - BURST_W'(1);
            addr_d = addr_q + ADDR_W'(1);
            if (cnt_q == BURST_W'(1)) state_d = ST_IDLE;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      addr_q  <= '0;
      rdv_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rdv_q   <= rd_issue;
    end
  end

  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = rdv_q[0];
  assign m1_readdatavalid = rdv_q[1];
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_sys_onchip_mem_arbiter.sv
// Directed bench for sys_onchip_mem_arbiter with a behavioural RAM whose
// unwritten words read back as 32'hA500_0000 | address.
module tb_sys_onchip_mem_arbiter;
  import sys_onchip_mem_pkg::*;

  localparam int AW = 13;
  localparam int DW = 32;
  localparam int BW = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [AW-1:0]   m0_address, m1_address;
  logic [DW/8-1:0] m0_byteenable, m1_byteenable;
  logic            m0_read, m0_write, m1_read, m1_write;
  logic [DW-1:0]   m0_writedata, m1_writedata;
  logic [BW-1:0]   m0_burstcount, m1_burstcount;
  logic            m0_waitrequest, m1_waitrequest;
  logic [DW-1:0]   m0_readdata, m1_readdata;
  logic            m0_readdatavalid, m1_readdatavalid;
  logic [AW-1:0]   mem_address;
  logic [DW/8-1:0] mem_byteenable;
  logic            mem_chipselect, mem_write;
  logic [DW-1:0]   mem_writedata, mem_readdata;
  arb_state_e      dbg_state;

  sys_onchip_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_W(BW)) dut (
    .clk              (clk),
    .reset            (reset),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_burstcount    (m0_burstcount),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_burstcount    (m1_burstcount),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_readdata     (mem_readdata),
    .dbg_state        (dbg_state)
  );

  // ---------------- RAM model ----------------
  logic [DW-1:0] wr_mem [int];
  logic [DW-1:0] rd_q;
  logic [DW-1:0] ram_w;

  function automatic logic [DW-1:0] ram_rd(input logic [AW-1:0] a);
    if (wr_mem.exists(int'(a))) return wr_mem[int'(a)];
    return 32'hA500_0000 | {19'd0, a};
  endfunction

  always @(posedge clk) begin
    if (mem_chipselect && mem_write) begin
      ram_w = ram_rd(mem_address);
      for (int b = 0; b < DW / 8; b++)
        if (mem_byteenable[b]) ram_w[8*b +: 8] = mem_writedata[8*b +: 8];
      wr_mem[int'(mem_address)] = ram_w;
    end
    if (mem_chipselect && !mem_write) rd_q <= ram_rd(mem_address);
  end
  assign mem_readdata = rd_q;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    m0_address = '0; m0_byteenable = 4'hF; m0_read = 1'b0; m0_write = 1'b0;
    m0_writedata = '0; m0_burstcount = 5'd1;
    m1_address = '0; m1_byteenable = 4'hF; m1_read = 1'b0; m1_write = 1'b0;
    m1_writedata = '0; m1_burstcount = 5'd1;
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled at the
  // falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic [AW-1:0] tie_addr [4];
  logic [AW-1:0] burst_addr [4];
  logic          wr_en [4];
  logic [AW-1:0] idx0, idx1, beat;
  logic          g0, g1;

  initial begin
    tie_addr   = '{13'h100, 13'h200, 13'h101, 13'h201};
    burst_addr = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001};
    wr_en      = '{1'b1, 1'b1, 1'b0, 1'b1};

    // Reset with a pending request: nothing may be accepted.
    idle_inputs();
    reset   = 1'b1;
    m0_read = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_m0_wait", 32'(m0_waitrequest), 32'd1);
    check("rst_m1_wait", 32'(m1_waitrequest), 32'd1);
    check("rst_cs", 32'(mem_chipselect), 32'd0);
    check("rst_wr", 32'(mem_write), 32'd0);
    check("rst_m0_rdv", 32'(m0_readdatavalid), 32'd0);
    check("rst_m1_rdv", 32'(m1_readdatavalid), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    m0_read = 1'b0;
    tick();
    reset = 1'b0;

    // Tie: both ports write single beats, grants alternate m0,m1,m0,m1.
    idx0 = '0; idx1 = '0;
    m0_write = 1'b1; m1_write = 1'b1;
    for (int k = 0; k < 4; k++) begin
      m0_address = 13'h100 + idx0; m0_writedata = 32'h1000 + 32'(idx0);
      m1_address = 13'h200 + idx1; m1_writedata = 32'h2000 + 32'(idx1);
      @(negedge clk);
      check("tie_addr", 32'(mem_address), 32'(tie_addr[k]));
      check("tie_m0_wait", 32'(m0_waitrequest), 32'(k % 2));
      check("tie_m1_wait", 32'(m1_waitrequest), 32'(1 - k % 2));
      check("tie_wr", 32'(mem_write), 32'd1);
      g0 = !m0_waitrequest; g1 = !m1_waitrequest;
      tick();
      if (g0) idx0 = idx0 + 13'd1;
      if (g1) idx1 = idx1 + 13'd1;
    end
    idle_inputs();
    check("tie_ram_100", ram_rd(13'h100), 32'h1000);
    check("tie_ram_101", ram_rd(13'h101), 32'h1001);
    check("tie_ram_200", ram_rd(13'h200), 32'h2000);
    check("tie_ram_201", ram_rd(13'h201), 32'h2001);

    // Single read from m0.
    m0_read = 1'b1; m0_address = 13'h0010; m0_burstcount = 5'd1;
    @(negedge clk);
    check("srd_addr", 32'(mem_address), 32'h10);
    check("srd_cs", 32'(mem_chipselect), 32'd1);
    check("srd_wr", 32'(mem_write), 32'd0);
    check("srd_be", 32'(mem_byteenable), 32'hF);
    check("srd_m0_wait", 32'(m0_waitrequest), 32'd0);
    tick();
    m0_read = 1'b0;
    @(negedge clk);
    check("srd_m0_rdv", 32'(m0_readdatavalid), 32'd1);
    check("srd_data", m0_readdata, 32'hA500_0010);
    check("srd_m1_rdv", 32'(m1_readdatavalid), 32'd0);
    check("srd_cs_after", 32'(mem_chipselect), 32'd0);

    // Read+write together is a write; partial byte lanes.
    tick();
    m0_read = 1'b1; m0_write = 1'b1; m0_address = 13'h0010;
    m0_byteenable = 4'b0101; m0_writedata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("rw_wr", 32'(mem_write), 32'd1);
    check("rw_be", 32'(mem_byteenable), 32'h5);
    tick();
    idle_inputs();
    @(negedge clk);
    check("rw_no_rdv", 32'(m0_readdatavalid), 32'd0);
    check("rw_ram", ram_rd(13'h0010), 32'hA5FF_00FF);

    // m1 read burst of 4 wrapping past the top of the address space.
    tick();
    m1_read = 1'b1; m1_address = 13'h1FFE; m1_burstcount = 5'd4;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 4) begin
        check("rb_addr", 32'(mem_address), 32'(burst_addr[k]));
        check("rb_cs", 32'(mem_chipselect), 32'd1);
      end else begin
        check("rb_cs_end", 32'(mem_chipselect), 32'd0);
        check("rb_state_end", 32'(dbg_state), 32'(ST_IDLE));
      end
      if (k >= 1 && k <= 3) begin
        check("rb_state", 32'(dbg_state), 32'(ST_RD_BURST));
        check("rb_m1_wait", 32'(m1_waitrequest), 32'd1);
      end
      check("rb_m1_rdv", 32'(m1_readdatavalid), (k > 0) ? 32'd1 : 32'd0);
      if (k > 0) check("rb_data", m1_readdata, 32'hA500_0000 | 32'(burst_addr[k-1]));
      check("rb_m0_rdv", 32'(m0_readdatavalid), 32'd0);
      tick();
      if (k == 0) m1_read = 1'b0;
    end

    // m0 write burst of 3 with one stall cycle; m1 read waits meanwhile.
    m0_write = 1'b1; m0_address = 13'h300; m0_burstcount = 5'd3;
    m1_read = 1'b1; m1_address = 13'h050; m1_burstcount = 5'd1;
    beat = '0;
    for (int k = 0; k < 4; k++) begin
      m0_write = wr_en[k];
      m0_writedata = 32'h3000 + 32'(beat);
      @(negedge clk);
      check("wb_m1_wait", 32'(m1_waitrequest), 32'd1);
      check("wb_cs", 32'(mem_chipselect), 32'(wr_en[k]));
      if (wr_en[k]) begin
        check("wb_addr", 32'(mem_address), 32'h300 + 32'(beat));
        check("wb_wr", 32'(mem_write), 32'd1);
        check("wb_m0_wait", 32'(m0_waitrequest), 32'd0);
      end else begin
        check("wb_stall_wait", 32'(m0_waitrequest), 32'd1);
      end
      tick();
      if (wr_en[k]) beat = beat + 13'd1;
    end
    m0_write = 1'b0;
    @(negedge clk);
    check("wb_m1_grant", 32'(m1_waitrequest), 32'd0);
    check("wb_m1_addr", 32'(mem_address), 32'h50);
    tick();
    m1_read = 1'b0;
    @(negedge clk);
    check("wb_m1_rdv", 32'(m1_readdatavalid), 32'd1);
    check("wb_m1_data", m1_readdata, 32'hA500_0050);
    check("wb_ram_300", ram_rd(13'h300), 32'h3000);
    check("wb_ram_301", ram_rd(13'h301), 32'h3001);
    check("wb_ram_302", ram_rd(13'h302), 32'h3002);

    // Reset in the middle of an 8-beat read burst.
    tick();
    m0_read = 1'b1; m0_address = 13'h400; m0_burstcount = 5'd8;
    @(negedge clk);
    check("rr_addr0", 32'(mem_address), 32'h400);
    tick();
    m0_read = 1'b0;
    @(negedge clk);
    check("rr_state", 32'(dbg_state), 32'(ST_RD_BURST));
    check("rr_addr1", 32'(mem_address), 32'h401);
    #1 reset = 1'b1;
    #1;
    check("rr_state_rst", 32'(dbg_state), 32'(ST_IDLE));
    check("rr_rdv_rst", 32'(m0_readdatavalid), 32'd0);
    check("rr_wait_rst", 32'(m0_waitrequest), 32'd1);
    check("rr_cs_rst", 32'(mem_chipselect), 32'd0);
    @(negedge clk);
    check("rr_rdv_next", 32'(m0_readdatavalid), 32'd0);
    tick();
    reset = 1'b0;
    m1_read = 1'b1; m1_address = 13'h020; m1_burstcount = 5'd1;
    @(negedge clk);
    check("rr_new_cs", 32'(mem_chipselect), 32'd1);
    check("rr_new_addr", 32'(mem_address), 32'h20);
    check("rr_new_wait", 32'(m1_waitrequest), 32'd0);
    tick();
    m1_read = 1'b0;
    @(negedge clk);
    check("rr_new_rdv", 32'(m1_readdatavalid), 32'd1);
    check("rr_new_data", m1_readdata, 32'hA500_0020);
    check("rr_new_m0_rdv", 32'(m0_readdatavalid), 32'd0);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
